// File: rtl/ftdi_pkg.sv
// Shared FTDI bridge definitions: byte width, default FIFO geometry and
// the TX/RX handshake state encodings.
package ftdi_pkg;
  localparam int BYTE_W    = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_AW    = 4;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_REQ    = 2'd1,
    TX_ACKLOW = 2'd2
  } tx_state_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_e;
endpackage

// File: rtl/ftdi_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head byte is always visible
// at out_rdata while not empty.
module ftdi_sync_fifo
  import ftdi_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_push,
  input  logic [BYTE_W-1:0] in_wdata,
  input  logic              in_pop,
  output logic [BYTE_W-1:0] out_rdata,
  output logic              out_full,
  output logic              out_empty,
  output logic [AW:0]       out_level
);
  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       level_q, level_d;
  logic              do_push, do_pop;

  assign out_full  = (level_q == (AW+1)'(DEPTH));
  assign out_empty = (level_q == '0);
  assign out_level = level_q;
  assign out_rdata = mem[rptr_q];

  // A push while full is only taken when the head leaves on the same edge.
  assign do_push = in_push && (!out_full || in_pop);
  assign do_pop  = in_pop && !out_empty;

  always_comb begin
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge in_clk) begin
    if (do_push) mem[wptr_q] <= in_wdata;
  end
endmodule

// File: rtl/ftdi_stream_bridge.sv
// Byte-stream bridge between a ready/valid user port and the four-phase
// FTDI controller handshakes, with one FWFT FIFO per direction.
module ftdi_stream_bridge
  import ftdi_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_tx_valid,
  input  logic [BYTE_W-1:0] in_tx_byte,
  output logic              out_tx_ready,
  output logic              out_rx_valid,
  output logic [BYTE_W-1:0] out_rx_byte,
  input  logic              in_rx_ready,
  output logic              out_tx_hsk_req,
  input  logic              in_tx_hsk_ack,
  output logic [BYTE_W-1:0] out_tx_data,
  input  logic              in_rx_hsk_req,
  output logic              out_rx_hsk_ack,
  input  logic [BYTE_W-1:0] in_rx_data,
  output logic              out_rx_en,
  output logic [AW:0]       out_tx_level,
  output logic [AW:0]       out_rx_level
);
  tx_state_e         tx_state_q, tx_state_d;
  rx_state_e         rx_state_q, rx_state_d;
  logic              tx_req_q, tx_req_d, rx_ack_q, rx_ack_d, rx_en_q, rx_en_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d, tx_head;
  logic              tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push, rx_pop;
  logic [AW:0]       rx_free;
  logic              rx_en_gate;

  ftdi_sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_push(in_tx_valid && !tx_full), .in_wdata(in_tx_byte),
    .in_pop(tx_pop), .out_rdata(tx_head),
    .out_full(tx_full), .out_empty(tx_empty), .out_level(out_tx_level)
  );

  ftdi_sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_push(rx_push), .in_wdata(in_rx_data),
    .in_pop(rx_pop), .out_rdata(out_rx_byte),
    .out_full(rx_full), .out_empty(rx_empty), .out_level(out_rx_level)
  );

  assign out_tx_ready   = !tx_full;
  assign out_rx_valid   = !rx_empty;
  assign out_tx_hsk_req = tx_req_q;
  assign out_tx_data    = tx_data_q;
  assign out_rx_hsk_ack = rx_ack_q;
  assign out_rx_en      = rx_en_q;
  assign rx_pop         = !rx_empty && in_rx_ready;
  assign rx_free        = (AW+1)'(DEPTH) - out_rx_level;
  // Read-permission gate; held open, flow control comes from free space.
  assign rx_en_gate     = 1'b1;

  // New requests also wait for ack low, so a reset mid-handshake cannot
  // start a fresh transfer against a stale acknowledge.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_req_d   = tx_req_q;
    tx_data_d  = tx_data_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (!tx_empty && !in_tx_hsk_ack) begin
        tx_data_d  = tx_head;
        tx_pop     = 1'b1;
        tx_req_d   = 1'b1;
        tx_state_d = TX_REQ;
      end
      TX_REQ: if (in_tx_hsk_ack) begin
        tx_req_d   = 1'b0;
        tx_state_d = TX_ACKLOW;
      end
      TX_ACKLOW: if (!in_tx_hsk_ack) tx_state_d = TX_IDLE;
      default: begin
        tx_req_d   = 1'b0;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_ack_d   = rx_ack_q;
    rx_push    = 1'b0;
    rx_en_d    = rx_en_gate && (rx_free >= (AW+1)'(2));
    case (rx_state_q)
      RX_IDLE: if (in_rx_hsk_req && (!rx_full || rx_pop)) begin
        rx_push    = 1'b1;
        rx_ack_d   = 1'b1;
        rx_state_d = RX_ACK;
      end
      RX_ACK: if (!in_rx_hsk_req) begin
        rx_ack_d   = 1'b0;
        rx_state_d = RX_IDLE;
      end
      default: begin
        rx_ack_d   = 1'b0;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      tx_state_q <= TX_IDLE;
      tx_req_q   <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_req_q   <= tx_req_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rx_state_q <= RX_IDLE;
      rx_ack_q   <= 1'b0;
      rx_en_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_ack_q   <= rx_ack_d;
      rx_en_q    <= rx_en_d;
    end
  end
endmodule

// File: tb/tb_ftdi_stream_bridge.sv
// Directed + random bench for ftdi_stream_bridge with TX/RX scoreboards.
module tb_ftdi_stream_bridge;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          in_clk = 1'b0;
  logic          in_rst = 1'b1;
  logic          in_tx_valid, in_rx_ready, in_rx_hsk_req;
  logic [7:0]    in_tx_byte, in_rx_data;
  logic          in_tx_hsk_ack = 1'b0;
  logic          out_tx_ready, out_rx_valid, out_tx_hsk_req, out_rx_hsk_ack, out_rx_en;
  logic [7:0]    out_rx_byte, out_tx_data;
  logic [AW:0]   out_tx_level, out_rx_level;

  int            checks = 0, failures = 0, mon_checks = 0, mon_fails = 0;
  int            tx_seen = 0, rx_pops = 0;
  logic [7:0]    tx_q[$], rx_q[$];
  logic          ack_auto = 1'b0, ack_force = 1'b0;
  logic          req_prev = 1'b0, ack_prev = 1'b0;
  logic [7:0]    data_prev = 8'h00;

  always #5 in_clk = ~in_clk;

  ftdi_stream_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_tx_valid(in_tx_valid), .in_tx_byte(in_tx_byte), .out_tx_ready(out_tx_ready),
    .out_rx_valid(out_rx_valid), .out_rx_byte(out_rx_byte), .in_rx_ready(in_rx_ready),
    .out_tx_hsk_req(out_tx_hsk_req), .in_tx_hsk_ack(in_tx_hsk_ack), .out_tx_data(out_tx_data),
    .in_rx_hsk_req(in_rx_hsk_req), .out_rx_hsk_ack(out_rx_hsk_ack), .in_rx_data(in_rx_data),
    .out_rx_en(out_rx_en), .out_tx_level(out_tx_level), .out_rx_level(out_rx_level)
  );

  // Controller TX side: ack follows req one cycle later, or is forced.
  always @(posedge in_clk) begin
    #1;
    in_tx_hsk_ack = ack_auto ? out_tx_hsk_req : ack_force;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mchk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    mon_checks++;
    assert (obs === exp) else begin
      mon_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge in_clk) begin
    if (!in_rst) begin
      if (in_tx_valid && out_tx_ready) tx_q.push_back(in_tx_byte);
      if (out_tx_hsk_req && !req_prev) begin
        tx_seen++;
        mchk("tx_req_rise_ack_low", ack_prev, 1'b0);
        if (tx_q.size() == 0) mchk("tx_unexpected_byte", out_tx_data, 32'hFFFF_FFFF);
        else mchk("tx_data_order", out_tx_data, tx_q.pop_front());
      end
      if (out_tx_hsk_req && req_prev) mchk("tx_data_stable", out_tx_data, data_prev);
      if (out_rx_valid && in_rx_ready) begin
        rx_pops++;
        if (rx_q.size() == 0) mchk("rx_unexpected_byte", out_rx_byte, 32'hFFFF_FFFF);
        else mchk("rx_data_order", out_rx_byte, rx_q.pop_front());
      end
    end
    req_prev  = out_tx_hsk_req;
    ack_prev  = in_tx_hsk_ack;
    data_prev = out_tx_data;
  end

  task automatic push_tx(input logic [7:0] b);
    int n = 0;
    in_tx_valid = 1'b1;
    in_tx_byte  = b;
    while (!out_tx_ready && n < 300) begin @(posedge in_clk); #1; n++; end
    chk("tx_push_ready", out_tx_ready, 1'b1);
    @(posedge in_clk); #1;
    in_tx_valid = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b);
    int n = 0;
    in_rx_data    = b;
    in_rx_hsk_req = 1'b1;
    rx_q.push_back(b);
    while (!out_rx_hsk_ack && n < 300) begin @(posedge in_clk); #1; n++; end
    chk("rx_ack_high", out_rx_hsk_ack, 1'b1);
    in_rx_hsk_req = 1'b0;
    n = 0;
    while (out_rx_hsk_ack && n < 300) begin @(posedge in_clk); #1; n++; end
    chk("rx_ack_low", out_rx_hsk_ack, 1'b0);
  endtask

  task automatic wait_tx_drain();
    int n = 0;
    while ((tx_q.size() != 0 || out_tx_level != 0 || out_tx_hsk_req || in_tx_hsk_ack) && n < 2000) begin
      @(posedge in_clk); #1; n++;
    end
    chk("tx_drain_queue", tx_q.size(), 0);
    chk("tx_drain_level", out_tx_level, 0);
  endtask

  task automatic wait_rx_ack_low();
    int n = 0;
    while (out_rx_hsk_ack && n < 50) begin @(posedge in_clk); #1; n++; end
    chk("rx_ack_release", out_rx_hsk_ack, 1'b0);
  endtask

  initial begin
    int n;
    in_tx_valid = 1'b0; in_tx_byte = 8'h00; in_rx_ready = 1'b0;
    in_rx_hsk_req = 1'b0; in_rx_data = 8'h00;
    repeat (3) @(posedge in_clk); #1;
    chk("rst_tx_req", out_tx_hsk_req, 1'b0);
    chk("rst_rx_ack", out_rx_hsk_ack, 1'b0);
    chk("rst_tx_data", out_tx_data, 8'h00);
    chk("rst_rx_en", out_rx_en, 1'b0);
    chk("rst_tx_ready", out_tx_ready, 1'b1);
    chk("rst_rx_valid", out_rx_valid, 1'b0);
    chk("rst_tx_level", out_tx_level, 0);
    chk("rst_rx_level", out_rx_level, 0);
    in_rst = 1'b0;
    @(posedge in_clk); #1;
    chk("rx_en_after_rst", out_rx_en, 1'b1);

    // Two bytes with a responsive controller
    ack_auto = 1'b1;
    push_tx(8'hA5);
    push_tx(8'h3C);
    wait_tx_drain();
    chk("tx_seen_two", tx_seen, 2);

    // 17 bytes with ack withheld: 16 queued + 1 in flight
    ack_auto = 1'b0; ack_force = 1'b0;
    for (int i = 0; i < 17; i++) push_tx(8'h40 + 8'(i));
    chk("tx_full_level", out_tx_level, 16);
    chk("tx_full_ready", out_tx_ready, 1'b0);
    chk("tx_inflight_req", out_tx_hsk_req, 1'b1);
    chk("tx_inflight_data", out_tx_data, 8'h40);
    ack_auto = 1'b1;
    wait_tx_drain();
    chk("tx_seen_nineteen", tx_seen, 19);

    // RX fill with the user stalled
    for (int i = 1; i <= 14; i++) rx_send(8'(i));
    repeat (2) @(posedge in_clk); #1;
    chk("rx_level_14", out_rx_level, 14);
    chk("rx_en_at_14", out_rx_en, 1'b1);
    rx_send(8'h0F);
    repeat (2) @(posedge in_clk); #1;
    chk("rx_level_15", out_rx_level, 15);
    chk("rx_en_at_15", out_rx_en, 1'b0);
    rx_send(8'h10);
    chk("rx_level_16", out_rx_level, 16);
    chk("rx_valid_full", out_rx_valid, 1'b1);
    in_rx_data = 8'h11; in_rx_hsk_req = 1'b1; rx_q.push_back(8'h11);
    repeat (4) @(posedge in_clk); #1;
    chk("rx_stall_no_ack", out_rx_hsk_ack, 1'b0);
    chk("rx_stall_level", out_rx_level, 16);
    in_rx_ready = 1'b1;
    @(posedge in_clk); #1;
    in_rx_ready = 1'b0;
    chk("rx_ack_after_pop", out_rx_hsk_ack, 1'b1);
    chk("rx_level_after_pop", out_rx_level, 16);
    in_rx_hsk_req = 1'b0;
    wait_rx_ack_low();

    // Simultaneous user pop and controller push at full
    in_rx_data = 8'h12; in_rx_hsk_req = 1'b1; rx_q.push_back(8'h12);
    in_rx_ready = 1'b1;
    @(posedge in_clk); #1;
    in_rx_ready = 1'b0;
    chk("rx_simul_level", out_rx_level, 16);
    chk("rx_simul_ack", out_rx_hsk_ack, 1'b1);
    in_rx_hsk_req = 1'b0;
    wait_rx_ack_low();
    in_rx_ready = 1'b1;
    n = 0;
    while (out_rx_valid && n < 100) begin @(posedge in_clk); #1; n++; end
    in_rx_ready = 1'b0;
    chk("rx_drain_queue", rx_q.size(), 0);
    chk("rx_pops_18", rx_pops, 18);

    // Reset while TX_REQ with ack high
    ack_auto = 1'b0; ack_force = 1'b0;
    @(posedge in_clk); #2;
    push_tx(8'h77);
    n = 0;
    while (!out_tx_hsk_req && n < 20) begin @(posedge in_clk); #1; n++; end
    chk("rst_mid_req_up", out_tx_hsk_req, 1'b1);
    ack_force = 1'b1;
    @(posedge in_clk); #2;
    in_rst = 1'b1;
    #1;
    chk("rst_mid_req_drop", out_tx_hsk_req, 1'b0);
    chk("rst_mid_data", out_tx_data, 8'h00);
    chk("rst_mid_level", out_tx_level, 0);
    repeat (2) @(posedge in_clk); #2;
    in_rst = 1'b0;
    push_tx(8'h88);
    repeat (4) @(posedge in_clk); #1;
    chk("rst_no_req_ack_high", out_tx_hsk_req, 1'b0);
    chk("rst_pending_level", out_tx_level, 1);
    ack_force = 1'b0;
    n = 0;
    while (!out_tx_hsk_req && n < 20) begin @(posedge in_clk); #1; n++; end
    chk("rst_req_after_ack_low", out_tx_hsk_req, 1'b1);
    chk("rst_req_data", out_tx_data, 8'h88);
    ack_auto = 1'b1;
    wait_tx_drain();

    // Concurrent random streaming in both directions
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          push_tx(8'($urandom));
          repeat ($urandom_range(0, 2)) @(posedge in_clk);
          #1;
        end
      end
      begin
        for (int j = 0; j < 200; j++) begin
          rx_send(8'($urandom));
          repeat ($urandom_range(0, 2)) @(posedge in_clk);
          #1;
        end
      end
      begin
        int k = 0;
        while (rx_pops < 218 && k < 20000) begin
          in_rx_ready = 1'($urandom_range(0, 1));
          @(posedge in_clk); #1;
          k++;
        end
        in_rx_ready = 1'b0;
      end
    join
    wait_tx_drain();
    chk("rand_tx_seen", tx_seen, 221);
    chk("rand_rx_pops", rx_pops, 218);
    chk("rand_rx_queue", rx_q.size(), 0);
    chk("rand_rx_level", out_rx_level, 0);

    checks   += mon_checks;
    failures += mon_fails;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
